// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle sequencer: walks fetch/decode/execute states and issues
// registered one-cycle control strobes to the PC, IR, accumulator and memory.
module instr_cycle_ctrl #(
  parameter int FETCH_CYCLES = 2,
  parameter bit HALT_STICKY  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       zero,
  input  logic [2:0] opcode,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, S0 = 4'd1, S1 = 4'd2, S2 = 4'd3, S3 = 4'd4,
    S4 = 4'd5, S5 = 4'd6, S6 = 4'd7, S7 = 4'd8, HALTED = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
    OP_XOR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111
  } op_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  state_t state, nxt;
  ctl_t   ctl, ctl_nxt;
  op_t    op;
  logic   alu_op;

  assign op     = op_t'(opcode);
  assign alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= ctl_nxt;
    end
  end

  // Strobes are computed for the state being entered so they are registered
  // and line up exactly with the cycle spent in that state.
  always_comb begin
    nxt     = IDLE;
    ctl_nxt = '0;
    if (state == HALTED) begin
      nxt          = HALTED;
      ctl_nxt.halt = 1'b1;
    end else if (ena) begin
      case (state)
        IDLE:    nxt = S0;
        S0:      nxt = (FETCH_CYCLES == 1) ? S2 : S1;
        S1:      nxt = S2;
        S2:      nxt = S3;
        S3:      nxt = (HALT_STICKY && op == OP_HLT) ? HALTED : S4;
        S4:      nxt = S5;
        S5:      nxt = S6;
        S6:      nxt = S7;
        S7:      nxt = S0;
        default: nxt = IDLE;
      endcase

      case (nxt)
        S0, S1: begin
          ctl_nxt.rd      = 1'b1;
          ctl_nxt.load_ir = 1'b1;
          ctl_nxt.inc_pc  = 1'b1;
        end
        S3, S4: begin
          ctl_nxt.rd          = alu_op;
          ctl_nxt.load_acc    = alu_op && (nxt == S4);
          ctl_nxt.datactl_ena = (op == OP_STO);
          ctl_nxt.wr          = (op == OP_STO) && (nxt == S4);
          ctl_nxt.load_pc     = (op == OP_JMP);
          ctl_nxt.inc_pc      = (op == OP_SKZ) && zero;
          ctl_nxt.halt        = (op == OP_HLT);
        end
        S5: begin
          ctl_nxt.datactl_ena = (op == OP_STO);
          ctl_nxt.halt        = (op == OP_HLT) && !HALT_STICKY;
        end
        HALTED:  ctl_nxt.halt = 1'b1;
        default: ctl_nxt = '0;
      endcase
    end
  end

  assign inc_pc      = ctl.inc_pc;
  assign load_pc     = ctl.load_pc;
  assign load_ir     = ctl.load_ir;
  assign load_acc    = ctl.load_acc;
  assign rd          = ctl.rd;
  assign wr          = ctl.wr;
  assign datactl_ena = ctl.datactl_ena;
  assign halt        = ctl.halt;
  assign state_o     = state;

endmodule
